ga_even_alu_seq: RTL and testbench

//  Parametrised, multi-cycle ALU for the even subalgebra of 5D conformal GA (basis e1,e2,e3,eo,ei).

---
 rtl/ga_even_alu_seq_pkg.sv | 146 ++++++++++++++
 rtl/ga_even_alu_seq_if.sv | 27 ++
 rtl/ga_even_alu_seq_norm_sat.sv | 26 ++
 rtl/ga_even_alu_seq.sv | 164 ++++++++++++++++
 tb/tb_ga_even_alu_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ga_even_alu_seq_pkg.sv
// Shared types and constants for the even-subalgebra CGA ALU: op codes, FSM states and the
// geometric-product routing table (target component(s) and sign for every pair of basis blades).
package ga_even_alu_seq_pkg;

  localparam int GA_EVEN_N = 16;

  localparam int IDX_S     = 0;
  localparam int IDX_E12   = 1;
  localparam int IDX_E13   = 2;
  localparam int IDX_E23   = 3;
  localparam int IDX_E1O   = 4;
  localparam int IDX_E2O   = 5;
  localparam int IDX_E3O   = 6;
  localparam int IDX_E1I   = 7;
  localparam int IDX_E2I   = 8;
  localparam int IDX_E3I   = 9;
  localparam int IDX_EOI   = 10;
  localparam int IDX_E123O = 11;
  localparam int IDX_E123I = 12;
  localparam int IDX_E12OI = 13;
  localparam int IDX_E13OI = 14;
  localparam int IDX_E23OI = 15;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_REV = 3'd3,
    OP_NEG = 3'd4
  } ga_even_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MAC  = 3'd2,
    ST_NORM = 3'd3,
    ST_DONE = 3'd4
  } ga_state_e;

  typedef struct packed {
    logic [1:0] n_terms;
    logic [3:0] k0;
    logic       s0;
    logic [3:0] k1;
    logic       s1;
  } ga_gp_entry_t;

  typedef ga_gp_entry_t [GA_EVEN_N-1:0] ga_gp_row_t;
  typedef ga_gp_row_t   [GA_EVEN_N-1:0] ga_gp_tab_t;

  // Reverse flips the sign of the ten bivector components only.
  localparam logic [GA_EVEN_N-1:0] REV_NEG_MASK = 16'h07FE;

  // Blade k = E * N with E a Euclidean mask (bit0 e1, bit1 e2, bit2 e3) and
  // N a null factor: 0 none, 1 eo, 2 ei, 3 eo^ei.
  function automatic logic [2:0] blade_emask(input logic [3:0] k);
    case (int'(k))
      IDX_E12, IDX_E12OI:  return 3'b011;
      IDX_E13, IDX_E13OI:  return 3'b101;
      IDX_E23, IDX_E23OI:  return 3'b110;
      IDX_E1O, IDX_E1I:    return 3'b001;
      IDX_E2O, IDX_E2I:    return 3'b010;
      IDX_E3O, IDX_E3I:    return 3'b100;
      IDX_E123O, IDX_E123I: return 3'b111;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] blade_null(input logic [3:0] k);
    case (int'(k))
      IDX_E1O, IDX_E2O, IDX_E3O, IDX_E123O: return 2'd1;
      IDX_E1I, IDX_E2I, IDX_E3I, IDX_E123I: return 2'd2;
      IDX_EOI, IDX_E12OI, IDX_E13OI, IDX_E23OI: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] blade_index(input logic [2:0] e, input logic [1:0] n);
    case ({n, e})
      5'b00_011: return 4'(IDX_E12);
      5'b00_101: return 4'(IDX_E13);
      5'b00_110: return 4'(IDX_E23);
      5'b01_001: return 4'(IDX_E1O);
      5'b01_010: return 4'(IDX_E2O);
      5'b01_100: return 4'(IDX_E3O);
      5'b10_001: return 4'(IDX_E1I);
      5'b10_010: return 4'(IDX_E2I);
      5'b10_100: return 4'(IDX_E3I);
      5'b11_000: return 4'(IDX_EOI);
      5'b01_111: return 4'(IDX_E123O);
      5'b10_111: return 4'(IDX_E123I);
      5'b11_011: return 4'(IDX_E12OI);
      5'b11_101: return 4'(IDX_E13OI);
      5'b11_110: return 4'(IDX_E23OI);
      default:   return 4'(IDX_S);
    endcase
  endfunction

  // (Ea Na)(Eb Nb) = (-1)^(|Na||Eb|) (Ea Eb)(Na Nb). Null products use eo.ei = -1:
  // eo ei = -1 + eoi, ei eo = -1 - eoi, eo eoi = eo, ei eoi = -ei, eoi eo = -eo, eoi ei = ei.
  function automatic ga_gp_tab_t ga_gen_gp_table();
    ga_gp_tab_t t;
    logic [2:0] ea, eb, em;
    logic [1:0] na, nb, n0, n1, nt;
    logic       sg, q0, q1;
    t = '0;
    for (int i = 0; i < GA_EVEN_N; i++) begin
      for (int j = 0; j < GA_EVEN_N; j++) begin
        ea = blade_emask(4'(i));
        eb = blade_emask(4'(j));
        na = blade_null(4'(i));
        nb = blade_null(4'(j));
        sg = 1'b0;
        for (int bi = 0; bi < 3; bi++)
          for (int ai = bi + 1; ai < 3; ai++)
            if (eb[bi] && ea[ai]) sg = ~sg;
        if ((na == 2'd1 || na == 2'd2) && (^eb)) sg = ~sg;
        em = ea ^ eb;
        nt = 2'd1; n0 = 2'd0; n1 = 2'd0; q0 = 1'b0; q1 = 1'b0;
        if (na == 2'd0) n0 = nb;
        else if (nb == 2'd0) n0 = na;
        else begin
          case ({na, nb})
            4'b0101, 4'b1010: nt = 2'd0;
            4'b0110: begin nt = 2'd2; q0 = 1'b1; n1 = 2'd3; end
            4'b1001: begin nt = 2'd2; q0 = 1'b1; n1 = 2'd3; q1 = 1'b1; end
            4'b0111: n0 = 2'd1;
            4'b1011: begin n0 = 2'd2; q0 = 1'b1; end
            4'b1101: begin n0 = 2'd1; q0 = 1'b1; end
            4'b1110: n0 = 2'd2;
            default: n0 = 2'd0;
          endcase
        end
        t[i][j].n_terms = nt;
        t[i][j].k0      = blade_index(em, n0);
        t[i][j].s0      = sg ^ q0;
        t[i][j].k1      = blade_index(em, n1);
        t[i][j].s1      = sg ^ q1;
      end
    end
    return t;
  endfunction

  localparam ga_gp_tab_t GP_TABLE = ga_gen_gp_table();

endpackage

// File: rtl/ga_even_alu_seq_if.sv
// Request/response bundle for the even-multivector ALU; signal suffixes are from the ALU's view.
interface ga_even_alu_seq_if #(
  parameter int COMP_W = 16
);
  localparam int VEC_W = 16 * COMP_W;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [VEC_W-1:0] op_a_i;
  logic [VEC_W-1:0] op_b_i;
  logic [2:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [VEC_W-1:0] result_o;
  logic             error_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, op_a_i, op_b_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, error_o, busy_o
  );

  modport master (
    output in_valid_i, op_a_i, op_b_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, error_o, busy_o
  );
endinterface

// File: rtl/ga_even_alu_seq_norm_sat.sv
// One-component normaliser: optional arithmetic right shift by FRAC_W, then clamp or wrap
// to COMP_W bits. Purely combinational; ovf_o flags any out-of-range value.
module ga_even_alu_seq_norm_sat #(
  parameter int ACC_W    = 38,
  parameter int COMP_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    shift_en_i,
  output logic [COMP_W-1:0]       comp_o,
  output logic                    ovf_o
);
  logic signed [ACC_W-1:0] shifted;
  logic                    in_range;

  assign shifted  = shift_en_i ? (acc_i >>> FRAC_W) : acc_i;
  assign in_range = (shifted[ACC_W-1:COMP_W-1] == {(ACC_W-COMP_W+1){shifted[ACC_W-1]}});
  assign ovf_o    = ~in_range;

  always_comb begin
    comp_o = shifted[COMP_W-1:0];
    if (SATURATE != 0 && !in_range)
      comp_o = shifted[ACC_W-1] ? {1'b1, {(COMP_W-1){1'b0}}} : {1'b0, {(COMP_W-1){1'b1}}};
  end
endmodule

// File: rtl/ga_even_alu_seq.sv
// Multi-cycle ALU on 16-component even CGA multivectors. Latency from accept edge: MUL 256/LANES+2,
// others 3. Accepts only in IDLE; result held in DONE until out_ready_i.
module ga_even_alu_seq
  import ga_even_alu_seq_pkg::*;
#(
  parameter int COMP_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int LANES    = 4,
  parameter int SATURATE = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ga_even_alu_seq_if.slave  bus
);
  localparam int ACC_W      = 2 * COMP_W + 6;
  localparam int MAC_CYCLES = 256 / LANES;
  localparam int CNT_W      = $clog2(MAC_CYCLES);
  localparam int VEC_W      = GA_EVEN_N * COMP_W;

  ga_state_e               state_q;
  logic [VEC_W-1:0]        a_q, b_q;
  logic [2:0]              op_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q [GA_EVEN_N];
  logic                    illegal_q;
  logic                    in_ready_q, out_valid_q, busy_q, error_q;
  logic [VEC_W-1:0]        result_q;

  logic signed [ACC_W-1:0] exec_d [GA_EVEN_N];
  logic signed [ACC_W-1:0] mac_d  [GA_EVEN_N];
  logic [VEC_W-1:0]        norm_res;
  logic [GA_EVEN_N-1:0]    norm_ovf;
  logic                    norm_shift;

  logic [3:0]                mac_ia, mac_ib;
  logic [31:0]               mac_bsel;
  logic signed [2*COMP_W-1:0] mac_prod;
  logic signed [ACC_W-1:0]   mac_pext;
  ga_gp_entry_t              mac_ent;

  function automatic logic signed [ACC_W-1:0] ext_acc(input logic [COMP_W-1:0] c);
    return ACC_W'($signed(c));
  endfunction

  function automatic logic signed [2*COMP_W-1:0] ext_mul(input logic [COMP_W-1:0] c);
    return (2*COMP_W)'($signed(c));
  endfunction

  always_comb begin
    for (int k = 0; k < GA_EVEN_N; k++) begin
      case (op_q)
        OP_ADD:  exec_d[k] = ext_acc(a_q[k*COMP_W +: COMP_W]) + ext_acc(b_q[k*COMP_W +: COMP_W]);
        OP_SUB:  exec_d[k] = ext_acc(a_q[k*COMP_W +: COMP_W]) - ext_acc(b_q[k*COMP_W +: COMP_W]);
        OP_NEG:  exec_d[k] = -ext_acc(a_q[k*COMP_W +: COMP_W]);
        OP_REV:  exec_d[k] = REV_NEG_MASK[k] ? -ext_acc(a_q[k*COMP_W +: COMP_W])
                                             :  ext_acc(a_q[k*COMP_W +: COMP_W]);
        default: exec_d[k] = '0;
      endcase
    end
  end

  // One a component per group of 16/LANES cycles; each lane takes the next b component.
  always_comb begin
    for (int k = 0; k < GA_EVEN_N; k++) mac_d[k] = acc_q[k];
    mac_ia   = cnt_q[CNT_W-1 -: 4];
    mac_ib   = '0;
    mac_bsel = '0;
    mac_prod = '0;
    mac_pext = '0;
    mac_ent  = '0;
    for (int l = 0; l < LANES; l++) begin
      mac_bsel = 32'(cnt_q) * 32'(LANES) + 32'(l);
      mac_ib   = mac_bsel[3:0];
      mac_prod = ext_mul(a_q[mac_ia*COMP_W +: COMP_W]) * ext_mul(b_q[mac_ib*COMP_W +: COMP_W]);
      mac_pext = ACC_W'(mac_prod);
      mac_ent  = GP_TABLE[mac_ia][mac_ib];
      if (mac_ent.n_terms != 2'd0)
        mac_d[mac_ent.k0] = mac_ent.s0 ? mac_d[mac_ent.k0] - mac_pext : mac_d[mac_ent.k0] + mac_pext;
      if (mac_ent.n_terms == 2'd2)
        mac_d[mac_ent.k1] = mac_ent.s1 ? mac_d[mac_ent.k1] - mac_pext : mac_d[mac_ent.k1] + mac_pext;
    end
  end

  assign norm_shift = (op_q == OP_MUL);

  for (genvar g = 0; g < GA_EVEN_N; g++) begin : g_norm
    ga_even_alu_seq_norm_sat #(
      .ACC_W    (ACC_W),
      .COMP_W   (COMP_W),
      .FRAC_W   (FRAC_W),
      .SATURATE (SATURATE)
    ) u_norm (
      .acc_i      (acc_q[g]),
      .shift_en_i (norm_shift),
      .comp_o     (norm_res[g*COMP_W +: COMP_W]),
      .ovf_o      (norm_ovf[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      for (int k = 0; k < GA_EVEN_N; k++) acc_q[k] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            a_q        <= bus.op_a_i;
            b_q        <= bus.op_b_i;
            op_q       <= bus.op_i;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
            for (int k = 0; k < GA_EVEN_N; k++) acc_q[k] <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (bus.op_i == OP_MUL) ? ST_MAC : ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc_q     <= exec_d;
          illegal_q <= (op_q > OP_NEG);
          state_q   <= ST_NORM;
        end
        ST_MAC: begin
          acc_q <= mac_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAC_CYCLES - 1)) state_q <= ST_NORM;
        end
        ST_NORM: begin
          result_q    <= norm_res;
          error_q     <= illegal_q | (|norm_ovf);
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.error_o     = error_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_ga_even_alu_seq.sv
// Directed bench: a saturating and a wrapping instance run in lockstep on identical stimulus.
module tb_ga_even_alu_seq;
  import ga_even_alu_seq_pkg::*;

  localparam int CW = 16;
  localparam int VW = 16 * CW;
  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ga_even_alu_seq_if #(.COMP_W(CW)) bus ();
  ga_even_alu_seq_if #(.COMP_W(CW)) bus_w ();

  assign bus_w.in_valid_i  = bus.in_valid_i;
  assign bus_w.op_a_i      = bus.op_a_i;
  assign bus_w.op_b_i      = bus.op_b_i;
  assign bus_w.op_i        = bus.op_i;
  assign bus_w.out_ready_i = bus.out_ready_i;

  ga_even_alu_seq #(.COMP_W(CW), .FRAC_W(8), .LANES(4), .SATURATE(1)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );
  ga_even_alu_seq #(.COMP_W(CW), .FRAC_W(8), .LANES(4), .SATURATE(0)) dut_w (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_w)
  );

  function automatic vec_t put(input vec_t v, input int k, input int val);
    vec_t r;
    r = v;
    r[k*CW +: CW] = 16'(val);
    return r;
  endfunction

  task automatic start_op(input logic [2:0] op, input vec_t a, input vec_t b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 400) begin @(negedge clk); n++; end
    if (bus.in_ready_o) begin
      bus.op_i = op; bus.op_a_i = a; bus.op_b_i = b; bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Latency counts rising edges from the accept edge (=1) to the edge that raises out_valid_o.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid_o && lat < 400) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid_o) lat = -1;
  endtask

  task automatic do_op(input logic [2:0] op, input vec_t a, input vec_t b, output int lat);
    bit ok;
    start_op(op, a, b, ok);
    if (ok) wait_valid(lat);
    else lat = -1;
  endtask

  task automatic consume();
    @(negedge clk); bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error_o); end
    checks++; if (bus.result_o !== '0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result_o); end
    checks++; if (bus_w.result_o !== '0) begin errors++; $display("FAIL reset_result_w got %h want 0", bus_w.result_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_sub_neg();
    vec_t a, b, e;
    int lat;
    bit ok;
    a = put(put('0, 0, 256), 1, -512);
    b = put(put('0, 0, 256), 1, 128);
    start_op(OP_ADD, a, b, ok);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL add_busy got %b want 1", bus.busy_o); end
    checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL add_in_ready got %b want 0", bus.in_ready_o); end
    if (ok) wait_valid(lat); else lat = -1;
    e = put(put('0, 0, 512), 1, -384);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL add_result got %h want %h", bus.result_o, e); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL add_error got %b want 0", bus.error_o); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL add_done_busy got %b want 0", bus.busy_o); end
    consume();
    do_op(OP_SUB, a, b, lat);
    e = put('0, 1, -640);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL sub_result got %h want %h", bus.result_o, e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sub_latency got %0d want 3", lat); end
    consume();
    do_op(OP_NEG, a, b, lat);
    e = put(put('0, 0, -256), 1, 512);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL neg_result got %h want %h", bus.result_o, e); end
    consume();
  endtask

  task automatic test_mul();
    vec_t a, b, e;
    int lat;
    a = put('0, IDX_E12, 256);
    do_op(OP_MUL, a, a, lat);
    e = put('0, IDX_S, -256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_e12sq got %h want %h", bus.result_o, e); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL mul_e12sq_error got %b want 0", bus.error_o); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL mul_latency got %0d want 66", lat); end
    consume();
    a = put('0, IDX_EOI, 256);
    do_op(OP_MUL, a, a, lat);
    e = put('0, IDX_S, 256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_eoisq got %h want %h", bus.result_o, e); end
    consume();
    a = put('0, IDX_E12, 256);
    b = put('0, IDX_E1O, 256);
    do_op(OP_MUL, a, b, lat);
    e = put('0, IDX_E2O, -256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_e12_e1o got %h want %h", bus.result_o, e); end
    consume();
    a = put(put('0, IDX_S, 256), IDX_E12, 256);
    b = put('0, IDX_E12, 256);
    do_op(OP_MUL, a, b, lat);
    e = put(put('0, IDX_S, -256), IDX_E12, 256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_multi got %h want %h", bus.result_o, e); end
    consume();
  endtask

  task automatic test_mul_two_term();
    vec_t a, b, e;
    int lat;
    a = put('0, IDX_E1O, 256);
    b = put('0, IDX_E1I, 256);
    do_op(OP_MUL, a, b, lat);
    e = put(put('0, IDX_S, 256), IDX_EOI, -256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_e1o_e1i got %h want %h", bus.result_o, e); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL mul_e1o_e1i_error got %b want 0", bus.error_o); end
    consume();
    do_op(OP_MUL, b, a, lat);
    e = put(put('0, IDX_S, 256), IDX_EOI, 256);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL mul_e1i_e1o got %h want %h", bus.result_o, e); end
    consume();
  endtask

  task automatic test_saturate();
    vec_t a, e;
    int lat;
    a = put('0, IDX_S, 32767);
    do_op(OP_MUL, a, a, lat);
    e = put('0, IDX_S, 32767);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL sat_mul_result got %h want %h", bus.result_o, e); end
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL sat_mul_error got %b want 1", bus.error_o); end
    e = put('0, IDX_S, -256);
    checks++; if (bus_w.result_o !== e) begin errors++; $display("FAIL wrap_mul_result got %h want %h", bus_w.result_o, e); end
    checks++; if (bus_w.error_o !== 1'b1) begin errors++; $display("FAIL wrap_mul_error got %b want 1", bus_w.error_o); end
    consume();
    a = put('0, IDX_S, -32768);
    do_op(OP_NEG, a, '0, lat);
    e = put('0, IDX_S, 32767);
    checks++; if ({bus.error_o, bus.result_o} !== {1'b1, e}) begin errors++; $display("FAIL sat_neg got %b/%h want 1/%h", bus.error_o, bus.result_o, e); end
    e = put('0, IDX_S, -32768);
    checks++; if ({bus_w.error_o, bus_w.result_o} !== {1'b1, e}) begin errors++; $display("FAIL wrap_neg got %b/%h want 1/%h", bus_w.error_o, bus_w.result_o, e); end
    consume();
  endtask

  task automatic test_illegal_rev();
    vec_t a, e;
    int lat;
    a = put(put('0, IDX_S, 77), IDX_E13, 9);
    do_op(3'd6, a, a, lat);
    checks++; if (bus.result_o !== '0) begin errors++; $display("FAIL illegal_result got %h want 0", bus.result_o); end
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL illegal_error got %b want 1", bus.error_o); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL illegal_latency got %0d want 3", lat); end
    consume();
    a = put(put(put(put(put('0, IDX_E12, 100), IDX_S, 5), IDX_E123O, 7), IDX_EOI, 3), IDX_E12OI, 9);
    do_op(OP_REV, a, '0, lat);
    e = put(put(put(put(put('0, IDX_E12, -100), IDX_S, 5), IDX_E123O, 7), IDX_EOI, -3), IDX_E12OI, 9);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL rev_result got %h want %h", bus.result_o, e); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL rev_error got %b want 0", bus.error_o); end
    consume();
  endtask

  task automatic test_back_to_back();
    vec_t a, b, e;
    int lat;
    a = put(put('0, 0, 256), 1, -512);
    b = put(put('0, 0, 256), 1, 128);
    e = put(put('0, 0, 512), 1, -384);
    do_op(OP_ADD, a, b, lat);
    @(negedge clk);
    bus.op_i = OP_SUB; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid_o, bus.in_ready_o, bus.result_o} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL hold_%0d got v=%b r=%b %h want v=1 r=0 %h", i, bus.out_valid_o, bus.in_ready_o, bus.result_o, e);
      end
    end
    bus.in_valid_i = 1'b0;
    consume();
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o} !== 2'b10) begin
      errors++; $display("FAIL release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready_o, bus.out_valid_o);
    end
    do_op(OP_SUB, a, b, lat);
    e = put('0, 1, -640);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL b2b_sub got %h want %h", bus.result_o, e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    consume();
  endtask

  task automatic test_reset_mid();
    vec_t a, b, e;
    int lat;
    bit ok;
    a = put('0, IDX_E12, 256);
    start_op(OP_MUL, a, a, ok);
    repeat (20) @(posedge clk); #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.busy_o); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.error_o} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_flags got %b want 1000", {bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.error_o});
    end
    checks++; if (bus.result_o !== '0) begin errors++; $display("FAIL mid_reset_result got %h want 0", bus.result_o); end
    @(negedge clk); rst_n = 1'b1;
    repeat (70) @(posedge clk); #1;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_no_output got %b want 0", bus.out_valid_o); end
    a = put(put('0, 0, 256), 1, -512);
    b = put(put('0, 0, 256), 1, 128);
    do_op(OP_ADD, a, b, lat);
    e = put(put('0, 0, 512), 1, -384);
    checks++; if (bus.result_o !== e) begin errors++; $display("FAIL post_reset_add got %h want %h", bus.result_o, e); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got %0d want 3", lat); end
    consume();
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.op_i        = 3'd0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    test_reset();
    test_add_sub_neg();
    test_mul();
    test_mul_two_term();
    test_saturate();
    test_illegal_rev();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
